// File: rtl/elevator_request_controller_if.sv
// rtl/elevator_request_controller_if.sv - car/call-button bundle between the car side and the request controller
interface elevator_request_controller_if #(
    parameter int NUM_FLOORS = 10
);
    logic [NUM_FLOORS-1:0] call_btn;
    logic [3:0]            current_floor;
    logic                  elevator_idle;
    logic [3:0]            requested_floor;
    logic [NUM_FLOORS-1:0] pending;
    logic                  door_open;
    logic                  busy;

    modport master (
        output call_btn, current_floor, elevator_idle,
        input  requested_floor, pending, door_open, busy
    );

    modport slave (
        input  call_btn, current_floor, elevator_idle,
        output requested_floor, pending, door_open, busy
    );
endinterface

// File: rtl/elevator_request_controller.sv
// rtl/elevator_request_controller.sv - SCAN-order call scheduler with pick-up on the way and timed door stops
module elevator_request_controller #(
    parameter int NUM_FLOORS  = 10,
    parameter int DOOR_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    elevator_request_controller_if.slave bus
);
    localparam int DCW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [DCW-1:0] DOOR_LAST = DCW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DISPATCH, MOVE, DOOR} state_t;

    state_t                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [NUM_FLOORS-1:0] btn_prev_q, btn_prev_d;
    logic [3:0]            req_q, req_d;
    logic                  dir_q, dir_d;
    logic                  door_open_q, door_open_d;
    logic                  busy_q, busy_d;
    logic [DCW-1:0]        door_cnt_q, door_cnt_d;

    logic [3:0]            cur;
    logic                  cur_valid;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic                  at_cur;
    logic                  above_found, below_found, pick_found, sel_found;
    logic [3:0]            above_floor, below_floor, pick_floor, sel_floor;
    logic                  sel_dir;

    // Target search: nearest pending floor above/below the car, and nearest
    // pending floor strictly between the car and its current target.
    always_comb begin
        cur         = bus.current_floor;
        cur_valid   = int'(cur) < NUM_FLOORS;
        cur_mask    = '0;
        above_found = 1'b0;
        above_floor = 4'd0;
        below_found = 1'b0;
        below_floor = 4'd0;
        pick_found  = 1'b0;
        pick_floor  = 4'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (i == int'(cur)) begin
                cur_mask[i] = 1'b1;
            end
            if (cur_valid && pending_q[i] && (i > int'(cur))) begin
                above_found = 1'b1;
                above_floor = 4'(i);
            end
            if (cur_valid && pending_q[i] && !dir_q &&
                (i > int'(cur)) && (i < int'(req_q))) begin
                pick_found = 1'b1;
                pick_floor = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cur_valid && pending_q[i] && (i < int'(cur))) begin
                below_found = 1'b1;
                below_floor = 4'(i);
            end
            if (cur_valid && pending_q[i] && dir_q &&
                (i < int'(cur)) && (i > int'(req_q))) begin
                pick_found = 1'b1;
                pick_floor = 4'(i);
            end
        end
        at_cur = |(pending_q & cur_mask);

        sel_found = 1'b1;
        sel_floor = cur;
        sel_dir   = dir_q;
        if (!cur_valid) begin
            sel_found = 1'b0;
        end else if (at_cur) begin
            sel_floor = cur;
        end else if (!dir_q) begin
            if (above_found) begin
                sel_floor = above_floor;
            end else if (below_found) begin
                sel_floor = below_floor;
                sel_dir   = 1'b1;
            end else begin
                sel_found = 1'b0;
            end
        end else begin
            if (below_found) begin
                sel_floor = below_floor;
            end else if (above_found) begin
                sel_floor = above_floor;
                sel_dir   = 1'b0;
            end else begin
                sel_found = 1'b0;
            end
        end
    end

    always_comb begin
        btn_prev_d = bus.call_btn;
        press      = bus.call_btn & ~btn_prev_q;
        if (state_q == DOOR) begin
            press = press & ~cur_mask;
        end
        clr_mask   = '0;
        state_d    = state_q;
        req_d      = req_q;
        dir_d      = dir_q;
        door_cnt_d = door_cnt_q;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                if (sel_found) begin
                    req_d   = sel_floor;
                    dir_d   = sel_dir;
                    state_d = MOVE;
                end else begin
                    state_d = IDLE;
                end
            end
            MOVE: begin
                if (cur_valid && (cur == req_q) && bus.elevator_idle) begin
                    state_d    = DOOR;
                    clr_mask   = cur_mask;
                    door_cnt_d = DOOR_LAST;
                end else if (pick_found) begin
                    req_d = pick_floor;
                end
            end
            DOOR: begin
                if (door_cnt_q == '0) begin
                    state_d = (|pending_q) ? DISPATCH : IDLE;
                end else begin
                    door_cnt_d = door_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clears only happen on arrival in MOVE, where a fresh press must survive.
        pending_d   = (pending_q & ~clr_mask) | press;
        door_open_d = (state_d == DOOR);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            btn_prev_q  <= bus.call_btn;
            req_q       <= 4'd0;
            dir_q       <= 1'b0;
            door_open_q <= 1'b0;
            busy_q      <= 1'b0;
            door_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            btn_prev_q  <= btn_prev_d;
            req_q       <= req_d;
            dir_q       <= dir_d;
            door_open_q <= door_open_d;
            busy_q      <= busy_d;
            door_cnt_q  <= door_cnt_d;
        end
    end

    assign bus.requested_floor = (state_q == IDLE) ? bus.current_floor : req_q;
    assign bus.pending         = pending_q;
    assign bus.door_open       = door_open_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_elevator_request_controller.sv
// tb/tb_elevator_request_controller.sv - directed checks of elevator_request_controller
module tb_elevator_request_controller;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    elevator_request_controller_if #(.NUM_FLOORS(10)) bus();

    elevator_request_controller #(
        .NUM_FLOORS (10),
        .DOOR_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [3:0] floor);
        reset             = 1'b1;
        bus.call_btn      = '0;
        bus.current_floor = floor;
        bus.elevator_idle = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic press(input logic [9:0] bits);
        bus.call_btn = bits;
        tick(1);
        bus.call_btn = '0;
    endtask

    task automatic door_len(input string tag, input int exp);
        int n = 0;
        while (bus.door_open && n < 200) begin
            n++;
            tick(1);
        end
        check(tag, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Single call to floor 3
        do_reset(4'd0);
        check("rst_pending", bus.pending, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_door", bus.door_open, 0);
        check("rst_req", bus.requested_floor, 0);
        press(10'h008);
        check("t1_pending", bus.pending, 10'h008);
        check("t1_busy_idle", bus.busy, 0);
        tick();
        check("t1_busy_dispatch", bus.busy, 1);
        tick();
        check("t1_req", bus.requested_floor, 3);
        bus.current_floor = 4'd12;
        tick();
        check("t1_badfloor_door", bus.door_open, 0);
        check("t1_badfloor_req", bus.requested_floor, 3);
        bus.current_floor = 4'd3;
        tick();
        check("t1_door", bus.door_open, 1);
        check("t1_pend_clr", bus.pending, 0);
        door_len("t1_door_len", 16);
        check("t1_back_idle", bus.busy, 0);

        // SCAN order 5, 7, 1 starting at floor 2 going up
        do_reset(4'd2);
        press(10'h0A2);
        check("scan_pend", bus.pending, 10'h0A2);
        tick(2);
        check("scan_req5", bus.requested_floor, 5);
        bus.current_floor = 4'd5;
        tick();
        check("scan_pend_after5", bus.pending, 10'h082);
        door_len("scan_door5", 16);
        tick();
        check("scan_req7", bus.requested_floor, 7);
        bus.current_floor = 4'd7;
        tick();
        check("scan_pend_after7", bus.pending, 10'h002);
        door_len("scan_door7", 16);
        tick();
        check("scan_req1", bus.requested_floor, 1);
        bus.current_floor = 4'd1;
        tick();
        check("scan_pend_after1", bus.pending, 0);
        door_len("scan_door1", 16);
        check("scan_idle", bus.busy, 0);

        // Pick-up at 4 while travelling 0 -> 6
        do_reset(4'd0);
        press(10'h040);
        tick(2);
        check("pk_req6", bus.requested_floor, 6);
        bus.current_floor = 4'd2;
        bus.elevator_idle = 1'b0;
        tick();
        press(10'h010);
        check("pk_pend", bus.pending, 10'h050);
        check("pk_req_still6", bus.requested_floor, 6);
        tick();
        check("pk_req4", bus.requested_floor, 4);
        bus.current_floor = 4'd4;
        bus.elevator_idle = 1'b1;
        tick();
        check("pk_door4", bus.door_open, 1);
        check("pk_pend_after4", bus.pending, 10'h040);
        door_len("pk_door_len", 16);
        tick();
        check("pk_req6_again", bus.requested_floor, 6);

        // Call at the current floor, then a repeat press during DOOR
        do_reset(4'd4);
        press(10'h010);
        check("cf_pend", bus.pending, 10'h010);
        tick(3);
        check("cf_door", bus.door_open, 1);
        press(10'h010);
        tick();
        check("cf_ignored", bus.pending, 0);
        door_len("cf_door_rest", 14);
        check("cf_idle", bus.busy, 0);
        check("cf_idle_req", bus.requested_floor, 4);

        // Button held through reset release
        reset             = 1'b1;
        bus.call_btn      = 10'h004;
        bus.current_floor = 4'd0;
        bus.elevator_idle = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        check("hold_pend", bus.pending, 0);
        check("hold_busy", bus.busy, 0);
        bus.call_btn = '0;
        tick();
        press(10'h004);
        check("hold_repress", bus.pending, 10'h004);

        // Reset in the middle of MOVE
        do_reset(4'd0);
        press(10'h0A2);
        tick(2);
        check("mr_busy", bus.busy, 1);
        check("mr_req", bus.requested_floor, 1);
        check("mr_pend", bus.pending, 10'h0A2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_rst_pend", bus.pending, 0);
        check("mr_rst_busy", bus.busy, 0);
        check("mr_rst_door", bus.door_open, 0);
        check("mr_rst_req", bus.requested_floor, 0);
        tick(2);
        check("mr_stays_idle", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/elevator_request_controller.md
ELEVATOR_REQUEST_CONTROLLER -- requirements
Module: elevator_request_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 10, number of served floors (0..NUM_FLOORS-1, max 16).
REQ-002 SHALL have parameter DOOR_CYCLES, default 16, clock cycles the door stays open per stop.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port call_btn  input  NUM_FLOORS  level call buttons, bit i = floor i.
REQ-006 SHALL have port current_floor  input  4  floor currently reported by the elevator car.
REQ-007 SHALL have port elevator_idle  input  1  high when the car is stopped (not moving).
REQ-008 SHALL have port requested_floor  output  4  target floor driven to the car.
REQ-009 SHALL have port pending  output  NUM_FLOORS  registered outstanding-call bitmap.
REQ-010 SHALL have port door_open  output  1  high while stopped at a serviced floor.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL detect presses as rising edges of call_btn, using a registered copy of the previous call_btn value.
REQ-013 SHALL set pending[i] on the cycle after a detected press of bit i.
REQ-014 SHALL ignore a press of floor current_floor while in DOOR (no pending set, no timer change).
REQ-015 SHALL hold a direction register dir (0=up, 1=down).
REQ-016 SHALL select the target combinationally: dir up -> lowest pending floor > current_floor, else highest pending floor < current_floor (dir flips to down); dir down is symmetric; a pending bit at current_floor wins over both.
REQ-017 SHALL implement states IDLE, DISPATCH, MOVE, DOOR.
REQ-018 IDLE: requested_floor = current_floor; any pending bit set -> DISPATCH next cycle.
REQ-019 DISPATCH (exactly 1 cycle): requested_floor and dir loaded from the selected target; -> MOVE.
REQ-020 MOVE: when current_floor == requested_floor and elevator_idle == 1 -> DOOR, and pending[requested_floor] clears on that same edge.
REQ-021 MOVE: a pending floor strictly between current_floor and requested_floor in the travel direction SHALL replace requested_floor on the next edge (pick-up on the way), the nearest such floor winning.
REQ-022 DOOR: door_open = 1 for exactly DOOR_CYCLES cycles, then -> DISPATCH if pending != 0, else IDLE.
REQ-023 A press and a clear of the same bit on the same edge SHALL leave the bit clear, except in MOVE, where the press wins.
REQ-024 SHALL ignore current_floor values >= NUM_FLOORS for arrival and target selection; the FSM stays in MOVE.
REQ-025 SHALL keep the door counter width at the minimum needed for DOOR_CYCLES, with no wrap before expiry.
REQ-026 SHALL drive all outputs from registers except requested_floor in IDLE.

Reset
REQ-027 On reset: state = IDLE, pending = 0, dir = up, requested_floor = 0, door_open = 0, busy = 0, door counter = 0.
REQ-028 During reset the previous-button register SHALL load call_btn, so a button held through reset release does not register a press.
REQ-029 Reset asserted in any state SHALL abort the operation on the next edge, with no pending bit retained.

Verification
REQ-030 Single call: reset, current_floor = 0, pulse call_btn[3] -> pending = 0x008, DISPATCH then MOVE with requested_floor = 3; car reports 3 and idle -> door_open high 16 cycles, pending = 0, then IDLE.
REQ-031 SCAN order: at floor 2, dir up, pending {1,5,7} -> service order 5, 7, 1; dir flips to down after 7.
REQ-032 Pick-up: moving 0 -> 6, press 4 while current_floor = 2 -> requested_floor becomes 4 next cycle; after the door at 4, dispatch to 6.
REQ-033 Call at the current floor: in IDLE at 4, press 4 -> DISPATCH, MOVE, DOOR within 3 cycles; press 4 again during DOOR -> ignored.
REQ-034 Held button through reset: call_btn[2] = 1 across reset deassertion -> pending stays 0; release and re-press -> pending[2] = 1.
REQ-035 Mid-operation reset: reset in MOVE with pending = 0x0A2 -> next cycle all outputs at reset values, state IDLE.
